// File: rtl/herloa_pkg.sv
// Shared helpers for the pipelined HERLOA adder: width helper, approximate
// lower-part function and a saturating adder sized at elaboration time.
package herloa_pkg;

    localparam int unsigned MaxW = 64;

    typedef logic [MaxW-1:0] word_t;

    function automatic int unsigned kw_of(int unsigned kmax);
        return (kmax < 2) ? 1 : $clog2(kmax + 1);
    endfunction

    // Returns {c, S_lower}; bits of S_lower at and above k are zero.
    function automatic logic [MaxW:0] herloa_lower(word_t a, word_t b, int unsigned k);
        logic [MaxW-1:0] s;
        logic            c;
        logic            g;
        s = '0;
        c = 1'b0;
        g = 1'b0;
        if (k == 1) begin
            s[0] = a[0] ^ b[0];
            c    = a[0] & b[0];
        end else if (k >= 2) begin
            for (int unsigned i = 0; i < MaxW; i++) begin
                if (i + 2 == k) g = a[i] & b[i];
            end
            for (int unsigned i = 0; i < MaxW; i++) begin
                if (i + 1 < k) s[i] = a[i] | b[i] | g;
                if (i + 1 == k) begin
                    s[i] = (a[i] ^ b[i]) | g;
                    c    = a[i] & b[i];
                end
            end
        end
        return {c, s};
    endfunction

    function automatic word_t sat_add(word_t acc, word_t inc, int unsigned w);
        logic [MaxW:0] s;
        logic [MaxW:0] lim;
        s   = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << w) - 65'd1;
        return (s > lim) ? lim[MaxW-1:0] : s[MaxW-1:0];
    endfunction

endpackage

// File: rtl/herloa_pipe_adder_if.sv
// Operand/result streaming bundle for herloa_pipe_adder.
interface herloa_pipe_adder_if
    import herloa_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned KMAX = 9
) ();
    localparam int unsigned KW = kw_of(KMAX);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [KW-1:0] k_sel;
    logic          out_valid;
    logic          out_ready;
    logic [N:0]    sum;
    logic [KW-1:0] sum_k;
    logic [N:0]    abs_err;

    modport master (
        output in_valid, a, b, k_sel, out_ready,
        input  in_ready, out_valid, sum, sum_k, abs_err
    );

    modport slave (
        input  in_valid, a, b, k_sel, out_ready,
        output in_ready, out_valid, sum, sum_k, abs_err
    );
endinterface

// File: rtl/herloa_err_stats.sv
// Saturating error statistics over accepted results; clear beats a
// simultaneous handshake.
module herloa_err_stats
    import herloa_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             fire_i,
    input  logic [N:0]       abs_err_i,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [ACC_W-1:0] err_sum_o,
    output logic [N:0]       err_max_o
);
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] err_sum_q, err_sum_d;
    logic [N:0]       err_max_q, err_max_d;
    word_t            cnt_sat, sum_sat;

    always_comb begin
        cnt_sat   = sat_add(word_t'(err_cnt_q), word_t'(abs_err_i != '0), CNT_W);
        sum_sat   = sat_add(word_t'(err_sum_q), word_t'(abs_err_i), ACC_W);
        err_cnt_d = err_cnt_q;
        err_sum_d = err_sum_q;
        err_max_d = err_max_q;
        if (clr_i) begin
            err_cnt_d = '0;
            err_sum_d = '0;
            err_max_d = '0;
        end else if (fire_i) begin
            err_cnt_d = cnt_sat[CNT_W-1:0];
            err_sum_d = sum_sat[ACC_W-1:0];
            if (abs_err_i > err_max_q) err_max_d = abs_err_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_sum_q <= err_sum_d;
            err_max_q <= err_max_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign err_sum_o = err_sum_q;
    assign err_max_o = err_max_q;
endmodule

// File: rtl/herloa_pipe_adder.sv
// Two-stage valid/ready HERLOA adder with per-beat approximation depth and
// an exact-sum error monitor. Interface parameters must match N/KMAX here.
module herloa_pipe_adder
    import herloa_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned KMAX  = 9,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    herloa_pipe_adder_if.slave  bus,
    input  logic                stats_clr,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [ACC_W-1:0]    err_sum,
    output logic [N:0]          err_max
);
    localparam int unsigned KW = kw_of(KMAX);

    logic          s1_valid_q, s1_valid_d;
    logic [N-1:0]  a1_q, a1_d, b1_q, b1_d;
    logic [KW-1:0] k1_q, k1_d;
    logic          s2_valid_q, s2_valid_d;
    logic [N:0]    sum_q, sum_d, abs_err_q, abs_err_d;
    logic [KW-1:0] sum_k_q, sum_k_d;

    logic          s1_load, s2_load, fire;
    logic [KW-1:0] k_eff;
    logic [MaxW:0] lower;
    logic [N:0]    a_hi, b_hi, hi_sum, approx, exact;

    always_comb begin
        s2_load = !s2_valid_q || bus.out_ready;
        s1_load = !s1_valid_q || s2_load;
        k_eff   = (bus.k_sel > KW'(KMAX)) ? KW'(KMAX) : bus.k_sel;

        // Upper part adds operands shifted down by k, then is shifted back up.
        lower  = herloa_lower(word_t'(a1_q), word_t'(b1_q), 32'(k1_q));
        a_hi   = {1'b0, a1_q} >> k1_q;
        b_hi   = {1'b0, b1_q} >> k1_q;
        hi_sum = a_hi + b_hi + {{N{1'b0}}, lower[MaxW]};
        approx = (hi_sum << k1_q) | {1'b0, lower[N-1:0]};
        exact  = {1'b0, a1_q} + {1'b0, b1_q};

        s1_valid_d = s1_valid_q;
        a1_d       = a1_q;
        b1_d       = b1_q;
        k1_d       = k1_q;
        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                a1_d = bus.a;
                b1_d = bus.b;
                k1_d = k_eff;
            end
        end

        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        sum_k_d    = sum_k_q;
        abs_err_d  = abs_err_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d     = approx;
                sum_k_d   = k1_q;
                abs_err_d = (approx >= exact) ? approx - exact : exact - approx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            k1_q       <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            sum_k_q    <= '0;
            abs_err_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            k1_q       <= k1_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            sum_k_q    <= sum_k_d;
            abs_err_q  <= abs_err_d;
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.sum       = sum_q;
    assign bus.sum_k     = sum_k_q;
    assign bus.abs_err   = abs_err_q;
    assign fire          = s2_valid_q && bus.out_ready;

    herloa_err_stats #(
        .N     (N),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) u_err_stats (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (stats_clr),
        .fire_i    (fire),
        .abs_err_i (abs_err_q),
        .err_cnt_o (err_cnt),
        .err_sum_o (err_sum),
        .err_max_o (err_max)
    );
endmodule
